// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Two-read / one-write register file with a per-register
//                pending scoreboard and a post-reset clear sequence. Define
//                REGFILE_BYPASS_EN to forward write data to same-cycle reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              pend_a,
    output logic              pend_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              ready
);

    localparam int              c_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_ready;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    logic [c_DEPTH-1:0]  r_pend;

    logic                w_clearing;
    logic                w_run;
    logic                w_wr_act;
    logic                w_mark_act;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_data;
    logic [ADDR_W-1:0]   w_rd_addr [2];

    // Reset is sampled synchronously, but outputs must already read as idle
    // during the cycle rst is high, so rst also gates the run qualifier.
    assign w_clearing = (r_state == ST_CLEAR) && !rst;
    assign w_run      = (r_state == ST_RUN) && !rst;
    assign w_wr_act   = w_run && wr_en &&
                        !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_mark_act = w_run && mark_en &&
                        !((ZERO_REG != 0) && (mark_addr == '0));

    assign ready = r_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            if (r_clr_cnt == c_LAST) begin
                r_state   <= ST_RUN;
                r_ready   <= 1'b1;
                r_clr_cnt <= '0;
            end else begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Clear sequence and write-back share the single storage write port.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = wr_addr;
        w_mem_data = wr_data;
        if (w_clearing) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_cnt;
            w_mem_data = '0;
        end else if (w_wr_act) begin
            w_mem_we   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Mark is applied after write so a same-address issue leaves pend set.
    always_ff @(posedge clk) begin
        if (w_clearing) begin
            r_pend[r_clr_cnt] <= 1'b0;
        end else begin
            if (w_wr_act) begin
                r_pend[wr_addr] <= 1'b0;
            end
            if (w_mark_act) begin
                r_pend[mark_addr] <= 1'b1;
            end
        end
    end

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [DATA_W-1:0] w_data;
        logic              w_pend;
        logic              w_zero_hit;

        assign w_zero_hit = (ZERO_REG != 0) && (w_rd_addr[gi] == '0);

`ifdef REGFILE_BYPASS_EN
        logic w_wr_hit;
        logic w_mark_hit;

        assign w_wr_hit   = w_wr_act && (wr_addr == w_rd_addr[gi]);
        assign w_mark_hit = w_mark_act && (mark_addr == w_rd_addr[gi]);

        always_comb begin
            w_data = '0;
            w_pend = 1'b0;
            if (w_run && !w_zero_hit) begin
                if (w_wr_hit) begin
                    w_data = wr_data;
                    w_pend = w_mark_hit;
                end else begin
                    w_data = r_mem[w_rd_addr[gi]];
                    w_pend = r_pend[w_rd_addr[gi]];
                end
            end
        end
`else
        always_comb begin
            w_data = '0;
            w_pend = 1'b0;
            if (w_run && !w_zero_hit) begin
                w_data = r_mem[w_rd_addr[gi]];
                w_pend = r_pend[w_rd_addr[gi]];
            end
        end
`endif
    end

    assign rd_data_a = g_rd[0].w_data;
    assign rd_data_b = g_rd[1].w_data;
    assign pend_a    = g_rd[0].w_pend;
    assign pend_b    = g_rd[1].w_pend;

endmodule
`default_nettype wire
